// File: rtl/gpio_in_ip.sv
// GPIO input peripheral: synchronized pin levels, polarity-selectable edge capture,
// W1C status and a maskable level interrupt. Define GPIO_IN_DEBOUNCE_EN for pin debouncing.
module gpio_in_ip #(
    parameter int WIDTH  = 32,
    parameter int DB_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [1:0]       addr,
    input  logic             write_en,
    input  logic [31:0]      wdata,
    input  logic             read_en,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic             irq
);
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_EDGE_POL = 2'd1;
    localparam logic [1:0] ADDR_STATUS   = 2'd2;
    localparam logic [1:0] ADDR_IRQ_EN   = 2'd3;

    logic [WIDTH-1:0] s0, s1, lvl, prev;
    logic [WIDTH-1:0] edge_pol, status, irq_en;
    logic [WIDTH-1:0] hit, hit_q, clr;
    logic [1:0]       warm_cnt;
    logic             wr_pol, wr_status, wr_irq_en;

    assign wr_pol    = sel && write_en && (addr == ADDR_EDGE_POL);
    assign wr_status = sel && write_en && (addr == ADDR_STATUS);
    assign wr_irq_en = sel && write_en && (addr == ADDR_IRQ_EN);

    // NOTE: reset is sampled inside the clocked block (synchronous) and all state uses <=.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= gpio_in;
            s1 <= s0;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int PW = $clog2(DB_DIV);

    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [WIDTH-1:0] h0, h1, lvl_q, agree_hi, agree_lo;

    // The 3-sample window is {s1, h0, h1}: the incoming sample plus the two held ones.
    assign tick     = (pre_cnt == PW'(DB_DIV - 1));
    assign agree_hi = s1 & h0 & h1;
    assign agree_lo = ~(s1 | h0 | h1);
    assign lvl      = lvl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            h0      <= '0;
            h1      <= '0;
            lvl_q   <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (tick) begin
                h0    <= s1;
                h1    <= h0;
                lvl_q <= (lvl_q | agree_hi) & ~agree_lo;
            end
        end
    end
`else
    assign lvl = s1;

    // DB_DIV only matters with debouncing; referenced so both builds share one parameter set.
    if (DB_DIV < 2) begin : g_db_div_unsupported
    end
`endif

    // Warm-up gating hides the level steps caused by the synchronizer filling after reset.
    assign hit   = (lvl & ~prev & edge_pol) | (~lvl & prev & ~edge_pol);
    assign hit_q = (warm_cnt == 2'd3) ? hit : '0;
    assign clr   = wr_status ? wdata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            warm_cnt <= '0;
            edge_pol <= '0;
            status   <= '0;
            irq_en   <= '0;
            irq      <= 1'b0;
        end else begin
            prev <= lvl;
            if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
            status <= (status & ~clr) | hit_q;
            if (wr_pol)    edge_pol <= wdata[WIDTH-1:0];
            if (wr_irq_en) irq_en   <= wdata[WIDTH-1:0];
            irq <= |(status & irq_en);
        end
    end

    always_comb begin
        // NOTE: default assignment first so every path drives rdata and no latch is inferred.
        rdata = 32'h0;
        if (sel && read_en) begin
            case (addr)
                ADDR_DATA:     rdata = 32'(lvl);
                ADDR_EDGE_POL: rdata = 32'(edge_pol);
                ADDR_STATUS:   rdata = 32'(status);
                ADDR_IRQ_EN:   rdata = 32'(irq_en);
                default:       rdata = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_in_ip.sv
// Self-checking bench for gpio_in_ip: directed scenarios plus randomized traffic
// checked against a pin-history reference model.
module tb_gpio_in_ip;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        write_en = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic        read_en = 1'b0;
    logic [31:0] rdata;
    logic [31:0] gpio_in = 32'h0;
    logic        irq;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    gpio_in_ip #(.WIDTH(32), .DB_DIV(4)) dut (
        .clk(clk), .rst(rst), .sel(sel), .addr(addr), .write_en(write_en),
        .wdata(wdata), .read_en(read_en), .rdata(rdata), .gpio_in(gpio_in), .irq(irq)
    );

    // Reference model: DATA shows the pin value from two edges back; edges are found by
    // comparing consecutive levels in the recorded pin history since the last reset.
    int          m_n = 0;
    logic [31:0] m_pins[$];
    logic [31:0] m_pol = 0, m_en = 0, m_status = 0, m_data = 0;
    logic [31:0] m_cur, m_old, m_hit, m_clr;
    logic        m_irq = 1'b0;

    function automatic logic [31:0] lvl_at(int e);
        return (e >= 3) ? m_pins[e-3] : 32'h0;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_n = 0;
            m_pins.delete();
            m_pol = 0; m_en = 0; m_status = 0; m_irq = 1'b0; m_data = 0;
        end else begin
            m_n++;
            m_pins.push_back(gpio_in);
            m_cur = lvl_at(m_n);
            m_old = lvl_at(m_n - 1);
            m_hit = (m_n >= 4) ? ((m_cur & ~m_old & m_pol) | (~m_cur & m_old & ~m_pol)) : 32'h0;
            m_clr = (sel && write_en && addr == 2'd2) ? wdata : 32'h0;
            m_irq = |(m_status & m_en);
            m_status = (m_status & ~m_clr) | m_hit;
            if (sel && write_en && addr == 2'd1) m_pol = wdata;
            if (sel && write_en && addr == 2'd3) m_en = wdata;
            m_data = lvl_at(m_n + 1);
        end
    endtask

    // Inputs are stable from the negedge to the posedge, so the model sees what the DUT sees.
    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; read_en = 1'b1; addr = a;
        #1;
        d = rdata;
        sel = 1'b0; read_en = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; write_en = 1'b1; addr = a; wdata = d;
        cycle();
        sel = 1'b0; write_en = 1'b0; wdata = 32'h0;
    endtask

    task automatic do_reset();
        gpio_in = 32'h0; sel = 1'b0; write_en = 1'b0; read_en = 1'b0;
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        repeat (5) cycle();
    endtask

    task automatic test_reset_zero();
        logic [31:0] d;
        gpio_in = 32'h0;
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            total++;
            if (d !== 32'h0) begin bad++; $display("FAIL reset_read addr=%0d got=%h exp=0", a, d); end
        end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    endtask

    task automatic test_reset_hold();
        logic [31:0] d;
        gpio_in = 32'hFFFF_FFFF;
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        rd(2'd0, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL hold_data_1 got=%h exp=0", d); end
        cycle();
        rd(2'd0, d);
        total++;
        if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL hold_data_2 got=%h exp=ffffffff", d); end
        repeat (6) cycle();
        rd(2'd2, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL hold_status got=%h exp=0", d); end
    endtask

    task automatic test_latency();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'h1);
        wr(2'd3, 32'h1);
        gpio_in = 32'h1;
        cycle();
        rd(2'd0, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL lat_data_n got=%h exp=0", d); end
        cycle();
        rd(2'd0, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL lat_data_n1 got=%h exp=1", d); end
        rd(2'd2, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL lat_status_n1 got=%h exp=0", d); end
        cycle();
        rd(2'd2, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL lat_status_n2 got=%h exp=1", d); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL lat_irq_n2 got=%b exp=0", irq); end
        cycle();
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL lat_irq_n3 got=%b exp=1", irq); end
    endtask

    task automatic test_polarity_w1c();
        logic [31:0] d;
        do_reset();
        wr(2'd3, 32'h20);
        gpio_in = 32'h20;
        repeat (4) cycle();
        rd(2'd2, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL pol_rise_ignored got=%h exp=0", d); end
        gpio_in = 32'h0;
        repeat (4) cycle();
        rd(2'd2, d);
        total++;
        if (d !== 32'h20) begin bad++; $display("FAIL pol_fall got=%h exp=20", d); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL pol_irq got=%b exp=1", irq); end
        gpio_in = 32'h20;
        repeat (4) cycle();
        rd(2'd2, d);
        total++;
        if (d !== 32'h20) begin bad++; $display("FAIL pol_rise_keep got=%h exp=20", d); end
        wr(2'd2, 32'h20);
        rd(2'd2, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL w1c_clear got=%h exp=0", d); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_lag got=%b exp=1", irq); end
        cycle();
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_drop got=%b exp=0", irq); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'h18);
        gpio_in = 32'h18;
        repeat (4) cycle();
        gpio_in = 32'h0;
        repeat (4) cycle();
        gpio_in = 32'h08;
        cycle(); cycle();
        wr(2'd2, 32'h18);
        rd(2'd2, d);
        total++;
        if (d[3] !== 1'b1) begin bad++; $display("FAIL sim_set_wins got=%b exp=1", d[3]); end
        total++;
        if (d !== 32'h08) begin bad++; $display("FAIL sim_status got=%h exp=08", d); end
    endtask

    task automatic test_masking();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'h3);
        gpio_in = 32'h3;
        repeat (4) cycle();
        wr(2'd3, 32'h4);
        cycle(); cycle();
        rd(2'd2, d);
        total++;
        if (d !== 32'h3) begin bad++; $display("FAIL mask_status got=%h exp=3", d); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_off got=%b exp=0", irq); end
        wr(2'd3, 32'h2);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_lag got=%b exp=0", irq); end
        cycle();
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq_on got=%b exp=1", irq); end
        sel = 1'b0; read_en = 1'b1; addr = 2'd2;
        #1;
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL rd_nosel got=%h exp=0", rdata); end
        sel = 1'b1; read_en = 1'b0;
        #1;
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL rd_noren got=%h exp=0", rdata); end
        sel = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] d;
        int op;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            sel = 1'b0; write_en = 1'b0; wdata = 32'h0; rst = 1'b0;
            rd(2'd0, d);
            total++;
            if (d !== m_data) begin bad++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, d, m_data); end
            rd(2'd1, d);
            total++;
            if (d !== m_pol) begin bad++; $display("FAIL rand_pol i=%0d got=%h exp=%h", i, d, m_pol); end
            rd(2'd2, d);
            total++;
            if (d !== m_status) begin bad++; $display("FAIL rand_status i=%0d got=%h exp=%h", i, d, m_status); end
            rd(2'd3, d);
            total++;
            if (d !== m_en) begin bad++; $display("FAIL rand_en i=%0d got=%h exp=%h", i, d, m_en); end
            total++;
            if (irq !== m_irq) begin bad++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, irq, m_irq); end
            gpio_in = gpio_in ^ ($urandom() & $urandom());
            rst = ($urandom_range(0, 99) == 0);
            op = $urandom_range(0, 9);
            if (op >= 6) begin
                sel = 1'b1; write_en = 1'b1; wdata = $urandom();
                addr = (op == 6) ? 2'd1 : (op == 7) ? 2'd3 : (op == 8) ? 2'd2 : 2'd0;
            end
            cycle();
        end
        sel = 1'b0; write_en = 1'b0; rst = 1'b0;
    endtask

`ifdef GPIO_IN_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'h4);
        wr(2'd3, 32'h4);
        gpio_in = 32'h4;
        repeat (4) cycle();
        gpio_in = 32'h0;
        repeat (20) cycle();
        rd(2'd0, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL db_glitch_data got=%h exp=0", d); end
        rd(2'd2, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL db_glitch_status got=%h exp=0", d); end
        gpio_in = 32'h4;
        repeat (24) cycle();
        rd(2'd0, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL db_stable_data got=%h exp=4", d); end
        rd(2'd2, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL db_stable_status got=%h exp=4", d); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL db_irq got=%b exp=1", irq); end
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            total++;
            if (d !== 32'h0) begin bad++; $display("FAIL db_reset addr=%0d got=%h exp=0", a, d); end
        end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL db_reset_irq got=%b exp=0", irq); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset_zero();
`ifdef GPIO_IN_DEBOUNCE_EN
        test_debounce();
`else
        test_reset_hold();
        test_latency();
        test_polarity_w1c();
        test_simultaneous();
        test_masking();
        test_random();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpio_in_ip.md
Name: gpio_in_ip

Overview:
- Memory-mapped GPIO input peripheral. It is the input-direction counterpart of the GPIO output register on the same IO bus.
- Samples external pins through a 2-flop synchronizer and exposes the level in a DATA register.
- Per-pin edge capture with selectable polarity, sticky write-1-to-clear status, and a maskable level interrupt to the core.
- Sits on the IO select decode alongside the other IO peripherals and uses the same sel / write_en / read_en / wdata / rdata bus.

Parameters:
- WIDTH, 32, number of input pins (1..32); rdata bits above WIDTH read 0.
- DB_DIV, 1000, debounce sample-tick period in clk cycles (used only with GPIO_IN_DEBOUNCE_EN; must be >= 2).

Ports:
- clk  input  1  system clock
- rst  input  1  reset: synchronous, active-high
- sel  input  1  peripheral select from IO address decode
- addr  input  2  register word index within the peripheral
- write_en  input  1  write strobe, qualified by sel
- wdata  input  32  write data
- read_en  input  1  read strobe, qualified by sel
- rdata  output  32  read data, combinational
- gpio_in  input  WIDTH  asynchronous external pins
- irq  output  1  registered interrupt request, active-high

Behaviour:
- Register map (addr):
  - 0 DATA, RO: synchronized pin levels (debounced if enabled).
  - 1 EDGE_POL, RW: per pin, 1 = capture rising edges, 0 = capture falling edges.
  - 2 STATUS, R/W1C: sticky edge flags.
  - 3 IRQ_EN, RW: per-pin interrupt mask.
- Writes to DATA are ignored.
- rdata = selected register (zero-extended) when sel && read_en, else 32'h0. Purely combinational, no read side effects.
- Register writes take effect at the clk edge where sel && write_en.
- Synchronizer: s0 <= gpio_in; s1 <= s0. The level value lvl = s1, or the debounced value when the feature is enabled. DATA reads lvl.
- Pin change setup-met before edge N is visible in DATA after edge N+1.
- Edge detect: prev <= lvl every cycle.
  - rise = lvl & ~prev; fall = ~lvl & prev.
  - hit = (rise & EDGE_POL) | (fall & ~EDGE_POL).
- STATUS update each cycle: STATUS <= (STATUS & ~clr) | hit_q, where clr = wdata[WIDTH-1:0] on a STATUS write, else 0.
  - Set wins when a W1C and a new hit land on the same bit in the same cycle.
- hit_q is gated by warm-up:
  - A 2-bit counter resets to 0 and increments to 3, then saturates.
  - hit_q = 0 while the counter < 3. This suppresses false edges from synchronizer fill after reset.
- irq <= |(STATUS & IRQ_EN), registered, so it is 1 cycle after STATUS.
  - Clearing the last enabled flag, or its IRQ_EN bit, deasserts irq one cycle later.
- End-to-end latency: pin edge before clk edge N -> STATUS bit set after edge N+2 -> irq high after edge N+3 (no debounce).
- Reset (mid-operation included) clears to 0, next cycle: s0, s1, prev, EDGE_POL, STATUS, IRQ_EN, irq, warm-up counter, and debounce state.
  - rdata follows the cleared registers.
- A pulse shorter than one clk may be missed; this is not a requirement.

Optional Feature:
- Macro: GPIO_IN_DEBOUNCE_EN.
- Defined:
  - A prescaler counts 0..DB_DIV-1 and emits a 1-cycle tick at DB_DIV-1, then wraps to 0.
  - On each tick, each pin shifts s1 into a 3-bit history.
  - lvl for a pin updates only when all 3 history bits agree, so a stable change appears within 3–4 ticks. Glitches shorter than 2 ticks never reach lvl.
  - Prescaler, history, and lvl reset to 0.
- Undefined: lvl = s1 directly; no prescaler or history logic is present.

Test Plan:
- Reset, then read all 4 addresses with gpio_in=0 -> rdata=0 for each. Hold gpio_in=32'hFFFF_FFFF through reset release -> STATUS stays 0 (warm-up suppresses), DATA=FFFF_FFFF after 2 cycles.
- Latency: EDGE_POL=1, IRQ_EN=1, gpio_in[0] 0->1 before edge N -> DATA[0]=1 after N+1, STATUS=1 after N+2, irq=1 after N+3.
- Polarity and W1C: EDGE_POL=0, pin 5 falls -> STATUS=32'h20. A rising edge on pin 5 leaves STATUS unchanged. Write STATUS=32'h20 -> STATUS=0, irq drops 1 cycle later.
- Simultaneous: W1C of bit 3 in the same cycle as a new hit on bit 3 -> STATUS[3] stays 1. Bit 4 cleared in that same write -> STATUS[4]=0.
- Masking: STATUS=32'h3, IRQ_EN=32'h4 -> irq=0. Write IRQ_EN=32'h2 -> irq=1 next cycle. Read with sel=0 or read_en=0 -> rdata=0.
- With GPIO_IN_DEBOUNCE_EN, DB_DIV=4: a 1-tick glitch on pin 2 -> DATA and STATUS unchanged. A stable high for 4 ticks -> DATA[2]=1 and one edge captured. Assert rst mid-count -> all state 0.
